// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-to-writeback pipeline stage of the RV64IM core.
// Selects the architectural result (ALU, extended load or PC+4), registers
// the register-file write port and serialises ecalls until ecall_ack.
// Optional feature macro: WB_RETIRE_COUNT_EN builds the 64-bit num_retired
// counter; when undefined num_retired is tied to zero.
module mem_wb_stage #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            validM,
  output logic            readyM,
  input  logic            RegWriteM,
  input  logic [1:0]      ResultSrcM,
  input  logic [4:0]      MemWriteReadSizeM,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] ReadDataM,
  input  logic [XLEN-1:0] PCPlus4M,
  input  logic [4:0]      RdM,
  input  logic            EcallM,
  input  logic            ecall_ack,
  output logic            enableW,
  output logic            RegWriteW1,
  output logic [4:0]      RdW1,
  output logic [XLEN-1:0] ResultW1,
  output logic            EcallW1,
  output logic [63:0]     num_retired
);

  typedef enum logic {
    RUN,
    ECALL_WAIT
  } state_t;

  state_t            state;
  state_t            stateNext;
  logic              transfer;
  logic [2:0]        funct3;
  logic [7:0]        byteSel;
  logic [15:0]       halfSel;
  logic [31:0]       wordSel;
  logic [XLEN-1:0]   loadData;
  logic [XLEN-1:0]   resultSel;
  logic              unusedSizeTag;

  // The access-kind tag is implied by ResultSrcM; only funct3 shapes the load.
  assign unusedSizeTag = ^MemWriteReadSizeM[4:3];
  assign funct3        = MemWriteReadSizeM[2:0];

  // readyM depends only on the state register, never on validM.
  assign readyM   = (state == RUN);
  assign transfer = validM & readyM;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= stateNext;
  end

  // Next-state: enter the wait on an ecall transfer, leave on the first ack.
  always_comb begin
    stateNext = state;
    unique case (state)
      RUN:        if (transfer && EcallM) stateNext = ECALL_WAIT;
      ECALL_WAIT: if (ecall_ack)          stateNext = RUN;
      default:    stateNext = RUN;
    endcase
  end

  // Load lane extraction and sign/zero extension from the doubleword.
  always_comb begin
    byteSel  = ReadDataM[{ALUResultM[2:0], 3'b000} +: 8];
    halfSel  = ReadDataM[{ALUResultM[2:1], 4'b0000} +: 16];
    wordSel  = ReadDataM[{ALUResultM[2], 5'b00000} +: 32];
    loadData = ReadDataM;
    unique case (funct3)
      3'b000:  loadData = {{(XLEN-8){byteSel[7]}}, byteSel};
      3'b100:  loadData = {{(XLEN-8){1'b0}}, byteSel};
      3'b001:  loadData = {{(XLEN-16){halfSel[15]}}, halfSel};
      3'b101:  loadData = {{(XLEN-16){1'b0}}, halfSel};
      3'b010:  loadData = {{(XLEN-32){wordSel[31]}}, wordSel};
      3'b110:  loadData = {{(XLEN-32){1'b0}}, wordSel};
      default: loadData = ReadDataM;
    endcase
  end

  // Architectural result select; the reserved encoding falls back to ALU.
  always_comb begin
    unique case (ResultSrcM)
      2'b01:   resultSel = loadData;
      2'b10:   resultSel = PCPlus4M;
      default: resultSel = ALUResultM;
    endcase
  end

  // Write-back register: strobes pulse per transfer, data fields hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      enableW    <= 1'b0;
      RegWriteW1 <= 1'b0;
      EcallW1    <= 1'b0;
      RdW1       <= '0;
      ResultW1   <= '0;
    end else if (transfer) begin
      enableW    <= 1'b1;
      RegWriteW1 <= RegWriteM & (RdM != 5'd0);
      EcallW1    <= EcallM;
      RdW1       <= RdM;
      ResultW1   <= resultSel;
    end else begin
      enableW    <= 1'b0;
      RegWriteW1 <= 1'b0;
      EcallW1    <= 1'b0;
    end
  end

`ifdef WB_RETIRE_COUNT_EN
  logic [63:0] retireCount;

  // Retired-instruction counter, wraps naturally at 2^64.
  always_ff @(posedge clk) begin
    if (reset)         retireCount <= '0;
    else if (transfer) retireCount <= retireCount + 64'd1;
  end

  assign num_retired = retireCount;
`else
  assign num_retired = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed vector table, hand-written ecall/reset
// sequences and randomized traffic against a behavioural reference model.
module tb_mem_wb_stage;

  logic        clk;
  logic        reset;
  logic        validM;
  logic        readyM;
  logic        RegWriteM;
  logic [1:0]  ResultSrcM;
  logic [4:0]  MemWriteReadSizeM;
  logic [63:0] ALUResultM;
  logic [63:0] ReadDataM;
  logic [63:0] PCPlus4M;
  logic [4:0]  RdM;
  logic        EcallM;
  logic        ecall_ack;
  logic        enableW;
  logic        RegWriteW1;
  logic [4:0]  RdW1;
  logic [63:0] ResultW1;
  logic        EcallW1;
  logic [63:0] num_retired;

  mem_wb_stage #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .validM(validM), .readyM(readyM),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
    .MemWriteReadSizeM(MemWriteReadSizeM), .ALUResultM(ALUResultM),
    .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M), .RdM(RdM), .EcallM(EcallM),
    .ecall_ack(ecall_ack), .enableW(enableW), .RegWriteW1(RegWriteW1),
    .RdW1(RdW1), .ResultW1(ResultW1), .EcallW1(EcallW1),
    .num_retired(num_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  // Reference model state: what the stage should present after each edge.
  logic        mWait;
  logic        mEn, mRw, mEc;
  logic [4:0]  mRd;
  logic [63:0] mRes;
  logic [63:0] mCnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  // Load value from the architectural rule: access size, aligned offset,
  // then shift, mask and optionally sign-fill.
  function automatic logic [63:0] loadVal(input logic [63:0] data, input logic [2:0] f3,
                                          input logic [2:0] o);
    int unsigned bytes;
    int unsigned off;
    logic [63:0] v, mask;
    bytes = 1 << f3[1:0];
    off   = int'(o) & ~(bytes - 1);
    v     = data >> (off * 8);
    if (bytes < 8) begin
      mask = (64'd1 << (bytes * 8)) - 64'd1;
      v    = v & mask;
      if (!f3[2] && v[bytes*8-1]) v = v | ~mask;
    end
    return v;
  endfunction

  function automatic logic [63:0] refResult();
    if (ResultSrcM == 2'b01) return loadVal(ReadDataM, MemWriteReadSizeM[2:0], ALUResultM[2:0]);
    if (ResultSrcM == 2'b10) return PCPlus4M;
    return ALUResultM;
  endfunction

  task automatic modelStep();
    logic xfer;
    if (reset) begin
      mWait = 0; mEn = 0; mRw = 0; mEc = 0; mRd = '0; mRes = '0; mCnt = '0;
    end else begin
      xfer = validM && !mWait;
      if (xfer) begin
        mEn  = 1;
        mRw  = RegWriteM && (RdM != 0);
        mEc  = EcallM;
        mRd  = RdM;
        mRes = refResult();
        mCnt = mCnt + 1;
      end else begin
        mEn = 0; mRw = 0; mEc = 0;
      end
      if (!mWait) mWait = xfer && EcallM;
      else        mWait = !ecall_ack;
    end
  endtask

  task automatic checkAll();
    check("readyM", 64'(readyM), 64'(!mWait));
    check("enableW", 64'(enableW), 64'(mEn));
    check("RegWriteW1", 64'(RegWriteW1), 64'(mRw));
    check("EcallW1", 64'(EcallW1), 64'(mEc));
    check("RdW1", 64'(RdW1), 64'(mRd));
    check("ResultW1", ResultW1, mRes);
`ifdef WB_RETIRE_COUNT_EN
    check("num_retired", num_retired, mCnt);
`else
    check("num_retired", num_retired, 64'd0);
`endif
  endtask

  // Predict, clock, then compare a little after the rising edge.
  task automatic cycle();
    modelStep();
    @(posedge clk);
    #1;
    checkAll();
  endtask

  task automatic idleInputs();
    validM = 0; RegWriteM = 0; ResultSrcM = 2'b00; MemWriteReadSizeM = '0;
    ALUResultM = '0; ReadDataM = '0; PCPlus4M = '0; RdM = '0;
    EcallM = 0; ecall_ack = 0;
  endtask

  task automatic aluOp(input logic [4:0] rd, input logic [63:0] val, input logic ecall);
    validM = 1; RegWriteM = 1; ResultSrcM = 2'b00; MemWriteReadSizeM = '0;
    ALUResultM = val; RdM = rd; EcallM = ecall;
  endtask

  typedef struct {
    logic [1:0]  src;
    logic [2:0]  f3;
    logic [63:0] alu;
    logic [63:0] pc4;
    logic [4:0]  rd;
    logic        rw;
    logic [63:0] expRes;
    logic        expRw;
  } vec_t;

  localparam logic [63:0] LD_DATA = 64'h8877_6655_4433_2281;

  vec_t vecs[14];
  int   ecHigh, rdyLow, enDuring;

  initial begin
    vecs[0]  = '{2'b00, 3'b000, 64'h1234,    64'h0,     5'd5,  1'b1, 64'h1234, 1'b1};
    vecs[1]  = '{2'b01, 3'b000, 64'h1000,    64'h0,     5'd6,  1'b1, 64'hFFFF_FFFF_FFFF_FF81, 1'b1};
    vecs[2]  = '{2'b01, 3'b100, 64'h1000,    64'h0,     5'd7,  1'b1, 64'h81, 1'b1};
    vecs[3]  = '{2'b01, 3'b001, 64'h1006,    64'h0,     5'd8,  1'b1, 64'hFFFF_FFFF_FFFF_8877, 1'b1};
    vecs[4]  = '{2'b01, 3'b110, 64'h1004,    64'h0,     5'd9,  1'b1, 64'h8877_6655, 1'b1};
    vecs[5]  = '{2'b01, 3'b011, 64'h1000,    64'h0,     5'd10, 1'b1, LD_DATA, 1'b1};
    vecs[6]  = '{2'b10, 3'b000, 64'h0,       64'h1_0004, 5'd1, 1'b1, 64'h1_0004, 1'b1};
    vecs[7]  = '{2'b11, 3'b000, 64'hABCD,    64'h5,     5'd11, 1'b1, 64'hABCD, 1'b1};
    vecs[8]  = '{2'b01, 3'b111, 64'h1003,    64'h0,     5'd12, 1'b1, LD_DATA, 1'b1};
    vecs[9]  = '{2'b01, 3'b010, 64'h1000,    64'h0,     5'd13, 1'b1, 64'h4433_2281, 1'b1};
    vecs[10] = '{2'b01, 3'b010, 64'h1005,    64'h0,     5'd14, 1'b1, 64'hFFFF_FFFF_8877_6655, 1'b1};
    vecs[11] = '{2'b01, 3'b101, 64'h1003,    64'h0,     5'd15, 1'b1, 64'h4433, 1'b1};
    vecs[12] = '{2'b01, 3'b000, 64'h1007,    64'h0,     5'd16, 1'b1, 64'hFFFF_FFFF_FFFF_FF88, 1'b1};
    vecs[13] = '{2'b00, 3'b000, 64'h77,      64'h0,     5'd0,  1'b1, 64'h77, 1'b0};

    // Reset, then idle: every output at its reset value.
    idleInputs();
    reset = 1;
    cycle();
    cycle();
    reset = 0;
    cycle();
    check("idle_readyM", 64'(readyM), 64'd1);
    check("idle_num_retired", num_retired, 64'd0);
    check("idle_RdW1", 64'(RdW1), 64'd0);

    // Vector table: one transfer each, result and write enable from the table.
    for (int i = 0; i < 14; i++) begin
      validM = 1; RegWriteM = vecs[i].rw; ResultSrcM = vecs[i].src;
      MemWriteReadSizeM = {(vecs[i].src == 2'b01) ? 2'b01 : 2'b00, vecs[i].f3};
      ALUResultM = vecs[i].alu; ReadDataM = LD_DATA; PCPlus4M = vecs[i].pc4;
      RdM = vecs[i].rd; EcallM = 0;
      cycle();
      check($sformatf("vec%0d_ResultW1", i), ResultW1, vecs[i].expRes);
      check($sformatf("vec%0d_RegWriteW1", i), 64'(RegWriteW1), 64'(vecs[i].expRw));
      check($sformatf("vec%0d_enableW", i), 64'(enableW), 64'd1);
    end
    idleInputs();
    cycle();
    check("hold_ResultW1", ResultW1, 64'h77);
    check("drop_enableW", 64'(enableW), 64'd0);

    // Back-to-back ALU ops, second one targets x0.
    aluOp(5'd5, 64'h1234, 0);
    cycle();
    check("b2b_first_RdW1", 64'(RdW1), 64'd5);
    check("b2b_first_RegWriteW1", 64'(RegWriteW1), 64'd1);
    aluOp(5'd0, 64'h99, 0);
    cycle();
    check("b2b_second_RegWriteW1", 64'(RegWriteW1), 64'd0);
    check("b2b_second_ResultW1", ResultW1, 64'h99);

    // Ecall stall: validM held, ack pulsed three cycles after the transfer.
    ecHigh = 0; rdyLow = 0; enDuring = 0;
    aluOp(5'd10, 64'h5D, 1);
    cycle();
    ecHigh += int'(EcallW1); rdyLow += int'(!readyM);
    aluOp(5'd11, 64'hBEEF, 0);
    for (int i = 0; i < 3; i++) begin
      ecall_ack = (i == 2);
      cycle();
      ecHigh += int'(EcallW1); rdyLow += int'(!readyM); enDuring += int'(enableW);
    end
    ecall_ack = 0;
    check("ecall_EcallW1_cycles", 64'(ecHigh), 64'd1);
    check("ecall_readyM_low_cycles", 64'(rdyLow), 64'd3);
    check("ecall_no_transfer_in_wait", 64'(enDuring), 64'd0);
    cycle();
    check("ecall_resume_RdW1", 64'(RdW1), 64'd11);
    check("ecall_resume_enableW", 64'(enableW), 64'd1);

    // Ack already present in the cycle after the ecall ends the wait at once.
    aluOp(5'd3, 64'h1, 1);
    cycle();
    ecall_ack = 1;
    aluOp(5'd4, 64'h2, 0);
    cycle();
    check("fast_ack_readyM", 64'(readyM), 64'd1);
    ecall_ack = 0;
    cycle();
    check("fast_ack_next_RdW1", 64'(RdW1), 64'd4);

    // Reset during the wait abandons it; a stale ack afterwards is ignored.
    aluOp(5'd9, 64'h3, 1);
    cycle();
    idleInputs();
    cycle();
    check("wait_before_reset", 64'(readyM), 64'd0);
    reset = 1;
    cycle();
    reset = 0;
    check("reset_in_wait_readyM", 64'(readyM), 64'd1);
    ecall_ack = 1;
    cycle();
    check("stale_ack_readyM", 64'(readyM), 64'd1);
    check("stale_ack_enableW", 64'(enableW), 64'd0);
    ecall_ack = 0;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 199) == 0);
      validM     = ($urandom_range(0, 9) < 7);
      RegWriteM  = 1'($urandom);
      ResultSrcM = 2'($urandom);
      MemWriteReadSizeM = 5'($urandom);
      ALUResultM = {$urandom, $urandom};
      ReadDataM  = {$urandom, $urandom};
      PCPlus4M   = {$urandom, $urandom};
      RdM        = 5'($urandom);
      EcallM     = ($urandom_range(0, 9) == 0);
      ecall_ack  = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
